// File: rtl/mc_datapath_param_pkg.sv
// mc_dp_pkg: mode encodings and FSM states shared by the multicycle datapath
package mc_dp_pkg;
  localparam logic [1:0] MODE_ADD4    = 2'b00;
  localparam logic [1:0] MODE_SUBDIFF = 2'b01;
  localparam logic [1:0] MODE_MUL     = 2'b10;
  localparam logic [1:0] MODE_MAX     = 2'b11;
  typedef enum logic [2:0] {IDLE, OP1, OP2, MUL, WB} state_t;
endpackage

// File: rtl/mc_datapath_param_mul.sv
// mc_seq_mul: radix-2 Booth signed multiplier, one iteration per cycle, N iterations
module mc_seq_mul
  import mc_dp_pkg::*;
#(
  parameter int N = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] product,
  output logic                  done
);
  localparam int CW = $clog2(N + 1);
  // one guard bit keeps acc safe when the multiplicand is the most negative value
  logic signed [N:0] acc, sum, m_x;
  logic [N-1:0] q, m;
  logic q1;
  logic [CW-1:0] cnt;
  always_comb begin
    m_x = {m[N-1], m};
    sum = ({q[0], q1} == 2'b01) ? acc + m_x : ({q[0], q1} == 2'b10) ? acc - m_x : acc;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      q   <= '0;
      q1  <= 1'b0;
      m   <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      q   <= b;
      q1  <= 1'b0;
      m   <= a;
      cnt <= CW'(N);
    end else if (cnt != '0) begin
      acc <= {sum[N], sum[N:1]};
      q   <= {sum[0], q[N-1:1]};
      q1  <= q[0];
      cnt <= cnt - 1'b1;
    end
  end
  assign done    = cnt == CW'(1);
  assign product = {acc[N-1:0], q};
endmodule

// File: rtl/mc_datapath_param.sv
// mc_datapath_param: multicycle four-operand datapath with one shared add/sub/max unit
// and a sequential Booth multiplier; optional saturation of the written result.
module mc_datapath_param
  import mc_dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic signed [WIDTH-1:0] C,
  input  logic signed [WIDTH-1:0] D,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf,
  output logic                    busy,
  output logic                    done
);
  localparam int TW = WIDTH + 1;
  localparam int UW = WIDTH + 2;
  localparam int FW = 2 * WIDTH + 2;
  localparam logic signed [FW-1:0] MAX_V = {{(WIDTH + 3){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_V = {{(WIDTH + 3){1'b1}}, {(WIDTH - 1){1'b0}}};
  state_t state;
  logic [1:0] md;
  logic signed [WIDTH-1:0] ra, rb, rc, rd;
  logic signed [TW-1:0] t1, t2;
  logic signed [UW-1:0] x, y, alu;
  logic signed [FW-1:0] product, full;
  logic sub, hi, lo, mul_done;
  // the shared unit sees A/B in OP1, C/D in OP2 and T1/T2 at write-back
  always_comb begin
    x    = state == OP1 ? {{2{ra[WIDTH-1]}}, ra} : state == OP2 ? {{2{rc[WIDTH-1]}}, rc} : {t1[TW-1], t1};
    y    = state == OP1 ? {{2{rb[WIDTH-1]}}, rb} : state == OP2 ? {{2{rd[WIDTH-1]}}, rd} : {t2[TW-1], t2};
    sub  = md == MODE_SUBDIFF || (state == OP2 && md == MODE_MUL);
    alu  = md == MODE_MAX ? (x > y ? x : y) : sub ? x - y : x + y;
    full = md == MODE_MUL ? product : {{(FW - UW){alu[UW-1]}}, alu};
    hi   = full > MAX_V;
    lo   = full < MIN_V;
  end
  mc_seq_mul #(.N(TW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (state == OP2 && md == MODE_MUL),
    .a       (t1),
    .b       (alu[TW-1:0]),
    .product (product),
    .done    (mul_done)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      md     <= MODE_ADD4;
      ra     <= '0;
      rb     <= '0;
      rc     <= '0;
      rd     <= '0;
      t1     <= '0;
      t2     <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= state == WB;
      case (state)
        IDLE: if (start) begin
          md    <= mode;
          ra    <= A;
          rb    <= B;
          rc    <= C;
          rd    <= D;
          state <= OP1;
        end
        OP1: begin
          t1    <= alu[TW-1:0];
          state <= OP2;
        end
        OP2: begin
          t2    <= alu[TW-1:0];
          state <= md == MODE_MUL ? MUL : WB;
        end
        MUL: if (mul_done) state <= WB;
        WB: begin
          result <= SAT ? (hi ? MAX_V[WIDTH-1:0] : lo ? MIN_V[WIDTH-1:0] : full[WIDTH-1:0]) : full[WIDTH-1:0];
          ovf    <= hi | lo;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
endmodule
